// File: rtl/zbt_pkg.sv
// rtl/zbt_pkg.sv - shared constants and types for the ZBT0 arbiter
//
// Purpose: slot phases, ZBT bus widths, pipeline latency and the capture
// FSM state encoding used by zbt0_arbiter and zbt_wdata_delay.
// Ports: none (package).
package zbt_pkg;

   localparam int ZBT_AW  = 19;
   localparam int ZBT_DW  = 36;
   localparam int ZBT_LAT = 2;

   // Phase 0 issues the renderer read; its data comes back ZBT_LAT phases later.
   localparam logic [1:0] SLOT_READ   = 2'd0;
   localparam logic [1:0] SLOT_RETURN = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_FULL    = 2'd2
   } zbt_state_t;

endpackage

// File: rtl/zbt_wdata_delay.sv
// rtl/zbt_wdata_delay.sv - fixed-length write-data delay line for ZBT late write
//
// Purpose: delays a data word by STAGES clocks so it meets the ZBT late-write
// data phase. All stages clear on reset so no stale write data survives.
// Ports:
//   clk      in   clock
//   reset_n  in   async active-low clear
//   d        in   W   data in
//   q        out  W   data delayed by STAGES clocks
module zbt_wdata_delay
   import zbt_pkg::*;
#(
   parameter int STAGES = ZBT_LAT,
   parameter int W      = ZBT_DW
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] pipe [STAGES];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= d;
         for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign q = pipe[STAGES-1];

endmodule

// File: rtl/zbt0_arbiter.sv
// rtl/zbt0_arbiter.sv - time-slot arbiter and capture controller for ZBT0
//
// Purpose: shares the ZBT0 port between the renderer (one read per 4-pixel
// group, phase 0) and the scanner (writes in phases 1..3), owns the write
// pointer and publishes the stored point count.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   hcount[10:0]        pixel counter, [1:0] is the slot phase
//   rd_addr / rd_data   renderer read address / captured read data
//   wr_valid/wr_ready/wr_data  scanner point stream
//   start / stop        capture control pulses
//   max_zbt_addr        published point count of the last completed capture
//   capturing/overflow  status
//   zbt_addr/zbt_we/zbt_write_data/zbt_read_data  ZBT0 port
module zbt0_arbiter
   import zbt_pkg::*;
#(
   parameter logic [ZBT_AW-1:0] DEPTH  = 19'h7FFFF,
   parameter int                RD_LAT = ZBT_LAT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [10:0]       hcount,
   input  logic [ZBT_AW-1:0] rd_addr,
   output logic [ZBT_DW-1:0] rd_data,
   input  logic              wr_valid,
   input  logic [ZBT_DW-1:0] wr_data,
   output logic              wr_ready,
   input  logic              start,
   input  logic              stop,
   output logic [ZBT_AW-1:0] max_zbt_addr,
   output logic              capturing,
   output logic              overflow,
   output logic [ZBT_AW-1:0] zbt_addr,
   output logic              zbt_we,
   output logic [ZBT_DW-1:0] zbt_write_data,
   input  logic [ZBT_DW-1:0] zbt_read_data
);

   zbt_state_t        state;
   logic [ZBT_AW:0]   wp;        // one bit wider so wp==DEPTH is representable
   logic [ZBT_AW:0]   wp_inc;
   logic [ZBT_AW:0]   depth_ext;
   logic [1:0]        phase;
   logic              accept;
   logic [ZBT_DW-1:0] wdata_q;
   logic              unused_hcount;

   assign phase         = hcount[1:0];
   assign unused_hcount = ^hcount[10:2];
   assign depth_ext     = {1'b0, DEPTH};
   assign wp_inc        = wp + 1'b1;

   assign wr_ready = (state == ST_CAPTURE) && (phase != SLOT_READ) && (wp < depth_ext);
   assign accept   = wr_valid && wr_ready;

   // Slot mux: read slot loads the renderer address, write slots load the
   // pointer only when a point is accepted; otherwise the address holds.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         zbt_addr <= '0;
         zbt_we   <= 1'b0;
         wdata_q  <= '0;
         rd_data  <= '0;
      end else begin
         zbt_we <= 1'b0;
         if (phase == SLOT_READ) begin
            zbt_addr <= rd_addr;
         end else if (accept) begin
            zbt_addr <= wp[ZBT_AW-1:0];
            zbt_we   <= 1'b1;
            wdata_q  <= wr_data;
         end
         if (phase == SLOT_RETURN) rd_data <= zbt_read_data;
      end
   end

   // wdata_q is aligned with zbt_addr; the delay line adds the late-write lag.
   zbt_wdata_delay #(
      .STAGES (RD_LAT),
      .W      (ZBT_DW)
   ) u_wdata_delay (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (wdata_q),
      .q       (zbt_write_data)
   );

   // Capture FSM. start outranks everything, including stop in the same
   // cycle. max_zbt_addr only changes when a capture ends, so the renderer
   // never wraps on a partially written frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         wp           <= '0;
         max_zbt_addr <= '0;
         capturing    <= 1'b0;
         overflow     <= 1'b0;
      end else if (start) begin
         state     <= ST_CAPTURE;
         capturing <= 1'b1;
         wp        <= '0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            ST_CAPTURE: begin
               if (accept) wp <= wp_inc;
               if (stop) begin
                  state        <= ST_IDLE;
                  capturing    <= 1'b0;
                  max_zbt_addr <= accept ? wp_inc[ZBT_AW-1:0] : wp[ZBT_AW-1:0];
               end else if (accept && (wp_inc == depth_ext)) begin
                  state        <= ST_FULL;
                  capturing    <= 1'b0;
                  max_zbt_addr <= DEPTH;
               end
            end
            ST_FULL: begin
               if (wr_valid) overflow <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zbt0_arbiter.sv
// tb/tb_zbt0_arbiter.sv - self-checking bench for zbt0_arbiter
module tb_zbt0_arbiter;

   localparam logic [19:0] DEPTH_BIG = 20'h7FFFF;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [10:0] hcount;
   logic [18:0] rd_addr;
   logic        wr_valid;
   logic [35:0] wr_data;
   logic        start;
   logic        stop;
   logic [35:0] zbt_read_data;

   logic [35:0] rd_data, rd_data_4;
   logic        wr_ready, wr_ready_4;
   logic [18:0] max_zbt_addr, max_zbt_addr_4;
   logic        capturing, capturing_4;
   logic        overflow, overflow_4;
   logic [18:0] zbt_addr, zbt_addr_4;
   logic        zbt_we, zbt_we_4;
   logic [35:0] zbt_write_data, zbt_write_data_4;

   zbt0_arbiter dut (
      .clk(clk), .reset_n(reset_n), .hcount(hcount), .rd_addr(rd_addr),
      .rd_data(rd_data), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready), .start(start), .stop(stop),
      .max_zbt_addr(max_zbt_addr), .capturing(capturing), .overflow(overflow),
      .zbt_addr(zbt_addr), .zbt_we(zbt_we), .zbt_write_data(zbt_write_data),
      .zbt_read_data(zbt_read_data)
   );

   zbt0_arbiter #(.DEPTH(19'd4)) dut4 (
      .clk(clk), .reset_n(reset_n), .hcount(hcount), .rd_addr(rd_addr),
      .rd_data(rd_data_4), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready_4), .start(start), .stop(stop),
      .max_zbt_addr(max_zbt_addr_4), .capturing(capturing_4), .overflow(overflow_4),
      .zbt_addr(zbt_addr_4), .zbt_we(zbt_we_4), .zbt_write_data(zbt_write_data_4),
      .zbt_read_data(zbt_read_data)
   );

   // ZBT memory model: address registered once, data presented the next cycle.
   logic [35:0] mem [0:63];
   logic [18:0] ra_q = '0;
   always @(posedge clk) ra_q <= zbt_addr;
   assign zbt_read_data = mem[ra_q[5:0]];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard of accepted writes for the full-depth instance.
   typedef struct {
      logic [18:0] addr;
      logic [35:0] data;
   } wr_t;
   wr_t exp_q[$];

   logic        s0v = 1'b0, s1v = 1'b0;
   logic [35:0] s0d = '0, s1d = '0;
   int          we4_count = 0;

   always @(negedge clk) begin
      wr_t e;
      if (reset_n) begin
         if (s1v) check("wdata", zbt_write_data, s1d);
         s1v = s0v;
         s1d = s0d;
         s0v = 1'b0;
         if (hcount[1:0] == 2'd1) check("we_after_read_slot", zbt_we, 0);
         if (zbt_we) begin
            if (exp_q.size() == 0) begin
               check("unexpected_we", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("waddr", zbt_addr, e.addr);
               s0v = 1'b1;
               s0d = e.data;
            end
         end
         if (zbt_we_4) we4_count++;
      end
   end

   // Reference capture model for the full-depth instance: 0 idle, 1 capture, 2 full.
   int          m_state = 0;
   logic [19:0] m_wp = '0;

   task automatic cyc(input logic v, input logic [35:0] d, input logic st,
                      input logic sp, output logic a);
      logic [1:0] p;
      logic       rdy;
      wr_valid = v;
      wr_data  = d;
      start    = st;
      stop     = sp;
      p   = hcount[1:0];
      rdy = (m_state == 1) && (p != 2'd0) && (m_wp < DEPTH_BIG);
      a   = v && rdy;
      #1 check("wr_ready", wr_ready, rdy);
      if (a) exp_q.push_back('{m_wp[18:0], d});
      if (st) begin
         m_state = 1;
         m_wp    = '0;
      end else if (m_state == 1) begin
         if (a) begin
            m_wp = m_wp + 1;
            if (m_wp == DEPTH_BIG) m_state = 2;
         end
         if (sp) m_state = 0;
      end
      @(posedge clk);
      #1;
      hcount   = hcount + 1;
      start    = 1'b0;
      stop     = 1'b0;
      wr_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, a);
   endtask

   // Feed n points with data base+1.. until accepted, bounded.
   task automatic write_n(input int n, input logic [35:0] base, input string name);
      logic a;
      int   k;
      k = 0;
      for (int i = 0; i < 8 * n + 8 && k < n; i++) begin
         cyc(1'b1, base + 36'(k + 1), 1'b0, 1'b0, a);
         if (a) k++;
      end
      if (k < n) check(name, k, n);
   endtask

   typedef struct {
      logic [18:0] addr;
      logic [35:0] exp;
   } rd_vec_t;
   rd_vec_t rv [4];

   initial begin
      logic a;
      int   guard;

      rv[0] = '{19'd5,  36'h0000ABCDE};
      rv[1] = '{19'd0,  36'h123456789};
      rv[2] = '{19'd63, 36'hFFFFFFFFF};
      rv[3] = '{19'd17, 36'h000000000};
      for (int i = 0; i < 64; i++) mem[i] = 36'(i) * 36'h111;
      for (int i = 0; i < 4; i++) mem[rv[i].addr[5:0]] = rv[i].exp;

      reset_n = 1'b0; hcount = '0; rd_addr = '0;
      wr_valid = 1'b0; wr_data = '0; start = 1'b0; stop = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1 hcount = hcount + 1;
      end
      check("rst_we", zbt_we, 0);
      check("rst_addr", zbt_addr, 0);
      check("rst_wdata", zbt_write_data, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_max", max_zbt_addr, 0);
      check("rst_capturing", capturing, 0);
      check("rst_overflow", overflow, 0);
      reset_n = 1'b1;

      // 8 sequential writes then stop.
      cyc(1'b0, '0, 1'b1, 1'b0, a);
      check("t1_capturing", capturing, 1);
      write_n(8, 36'h0, "t1_budget");
      cyc(1'b0, '0, 1'b0, 1'b1, a);
      idle(4);
      check("t1_max", max_zbt_addr, 8);
      check("t1_capturing_end", capturing, 0);
      check("t1_drain", exp_q.size(), 0);

      // Renderer reads, table driven.
      for (int i = 0; i < 4; i++) begin
         rd_addr = rv[i].addr;
         guard = 0;
         while (hcount[1:0] != 2'd0 && guard < 8) begin idle(1); guard++; end
         guard = 0;
         while (hcount[1:0] != 2'd3 && guard < 8) begin idle(1); guard++; end
         check("rd_after_phase2", rd_data, rv[i].exp);
         idle(2);
         check("rd_hold_phase1", rd_data, rv[i].exp);
      end

      // Restart mid-capture: max keeps old value, pointer returns to 0.
      cyc(1'b0, '0, 1'b1, 1'b0, a);
      write_n(3, 36'h100, "t3_budget");
      cyc(1'b0, '0, 1'b1, 1'b0, a);
      idle(2);
      check("t3_max_kept", max_zbt_addr, 8);
      a = 1'b0;
      for (int i = 0; i < 8 && !a; i++) cyc(1'b1, 36'h201, 1'b0, 1'b0, a);
      check("t3_restart_addr0", zbt_addr, 0);
      write_n(1, 36'h201, "t3_budget2");
      cyc(1'b0, '0, 1'b0, 1'b1, a);
      idle(3);
      check("t3_max_new", max_zbt_addr, 2);

      // start and stop together with an accepted write.
      cyc(1'b0, '0, 1'b1, 1'b0, a);
      write_n(1, 36'h300, "t4_budget");
      guard = 0;
      while (hcount[1:0] == 2'd0 && guard < 4) begin idle(1); guard++; end
      cyc(1'b1, 36'h3AA, 1'b1, 1'b1, a);
      check("t4_we", zbt_we, 1);
      check("t4_capturing", capturing, 1);
      check("t4_max_kept", max_zbt_addr, 2);
      a = 1'b0;
      for (int i = 0; i < 8 && !a; i++) cyc(1'b1, 36'h3BB, 1'b0, 1'b0, a);
      check("t4_addr0", zbt_addr, 0);
      cyc(1'b0, '0, 1'b0, 1'b1, a);
      idle(3);
      check("t4_max", max_zbt_addr, 1);

      // DEPTH=4 instance: fill, overflow, then start clears overflow.
      cyc(1'b0, '0, 1'b1, 1'b0, a);
      idle(1);
      we4_count = 0;
      for (int i = 0; i < 16; i++) cyc(1'b1, 36'h400 + 36'(i), 1'b0, 1'b0, a);
      idle(4);
      check("d4_writes", we4_count, 4);
      check("d4_max", max_zbt_addr_4, 4);
      check("d4_overflow", overflow_4, 1);
      check("d4_capturing", capturing_4, 0);
      check("d4_wr_ready", wr_ready_4, 0);
      check("big_no_overflow", overflow, 0);
      cyc(1'b0, '0, 1'b1, 1'b0, a);
      check("d4_ovf_cleared", overflow_4, 0);
      check("d4_recapture", capturing_4, 1);
      cyc(1'b0, '0, 1'b0, 1'b1, a);
      idle(4);
      check("d4_drain", exp_q.size(), 0);

      // Reset during an in-flight write.
      cyc(1'b0, '0, 1'b1, 1'b0, a);
      a = 1'b0;
      for (int i = 0; i < 8 && !a; i++) cyc(1'b1, 36'hDEADBEEF5, 1'b0, 1'b0, a);
      check("t6_we_before", zbt_we, 1);
      reset_n = 1'b0;
      #1;
      check("t6_we_abort", zbt_we, 0);
      check("t6_max", max_zbt_addr, 0);
      check("t6_capturing", capturing, 0);
      exp_q.delete();
      s0v = 1'b0;
      s1v = 1'b0;
      m_state = 0;
      m_wp = '0;
      repeat (2) begin
         @(posedge clk);
         #1 hcount = hcount + 1;
      end
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         idle(1);
         check("t6_no_wdata", zbt_write_data, 0);
      end
      check("t6_drain", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/zbt0_arbiter.md
# zbt0_arbiter

Time-slot arbiter and capture controller for the ZBT0 point-cloud memory. It shares the single ZBT0 port between two users. The scanner pipeline writes 36-bit points sequentially. The display renderer reads one point per 4-pixel group, slaved to hcount. It also owns the write pointer and publishes `max_zbt_addr`, the stored point count the renderer wraps on.

## Interface
Parameters:
- DEPTH, 19'h7FFFF: number of point slots; capture stops when the write pointer reaches DEPTH.
- RD_LAT, 2: ZBT read/write pipeline latency in cycles. Fixed; any other value is unsupported.

Ports (clock/reset fixed: one clock; reset is asynchronous and active-low):
- clk  in  1  system clock (65 MHz pixel clock)
- reset_n  in  1  async active-low reset
- hcount  in  11  pixel counter; only [1:0] (slot phase) used
- rd_addr  in  19  renderer read address
- rd_data  out  36  last point read for renderer
- wr_valid  in  1  scanner point available
- wr_data  in  36  point {6'b0, x[9:0], y[9:0], 6'b0, z[9:0]} (packing opaque here)
- wr_ready  out  1  point accepted this cycle when wr_valid&&wr_ready
- start  in  1  pulse: begin new capture at address 0
- stop  in  1  pulse: end capture, publish count
- max_zbt_addr  out  19  published point count
- capturing  out  1  high in CAPTURE state
- overflow  out  1  sticky: wr_valid seen while FULL; cleared by start
- zbt_addr  out  19  ZBT0 address
- zbt_we  out  1  ZBT0 write enable, active high
- zbt_write_data  out  36  ZBT0 write data
- zbt_read_data  in  36  ZBT0 read data

## Operation
- Slot phase p = hcount[1:0].
  - p==0 is the read slot: zbt_addr=rd_addr, zbt_we=0.
  - p==1,2,3 are write slots.
  - All zbt_* outputs are registered.
- States: IDLE (after reset), CAPTURE, FULL.
- IDLE→CAPTURE on start; wp←0, overflow←0.
- CAPTURE:
  - wr_ready = (p!=0) && (wp<DEPTH).
  - On an accepted write: zbt_addr←wp, zbt_we←1, wp←wp+1.
  - If wp+1==DEPTH, go FULL and set max_zbt_addr←DEPTH.
  - On stop: max_zbt_addr←wp (including a write accepted the same cycle), go IDLE.
- FULL: wr_ready=0. A cycle with wr_valid sets overflow. start→CAPTURE.
- start in any state restarts the capture (wp←0). max_zbt_addr keeps its old value until the capture ends, so the renderer never sees a partial frame.
- start and stop in the same cycle: start wins.
- A write slot with no accepted write is idle: zbt_we=0, zbt_addr holds.
- Write data: wr_data is delayed RD_LAT cycles through a shift register and driven on zbt_write_data, aligned to the ZBT late-write protocol.
- Read capture: the read issued at phase 0 returns at phase 2. rd_data←zbt_read_data on that edge and holds otherwise. The renderer sampling rd_data at phase 1 of the next group therefore sees stable data.

## Timing
- Reset values:
  - zbt_we=0, zbt_addr=0, zbt_write_data=0
  - rd_data=0, wr_ready=0, wp=0
  - max_zbt_addr=0, capturing=0, overflow=0
  - state IDLE; delay pipeline cleared
- Write: wr_valid&&wr_ready at edge n → zbt_we/zbt_addr valid after edge n+1 → zbt_write_data valid after edge n+3.
- Read: rd_addr is sampled at the edge ending phase 0. rd_data updates at the edge ending phase 2 and is stable for 4 cycles.
- Peak write throughput is 3 points per 4 cycles. The scanner must tolerate wr_ready low for 1 cycle in 4.
- reset_n asserted mid-operation aborts any in-flight write. ZBT contents are undefined; max_zbt_addr returns to 0.
- wp is 20 bits internally so wp==DEPTH is representable; comparisons are unsigned.

## Structure
- Shared package zbt_pkg:
  - slot constants SLOT_READ=2'd0
  - state encodings IDLE/CAPTURE/FULL
  - ZBT_LAT=2
  - ZBT_AW=19, ZBT_DW=36
- One sub-module: zbt_wdata_delay, a parameterised RD_LAT-stage 36-bit delay line with async clear.
- FSM, pointer and slot mux stay in the top level.

## Test plan
- Reset then start, wr_valid held high with data 36'h1, 2, 3…, 8 writes then stop → zbt_we never high at p==0; zbt_addr 0..7; data k appears on zbt_write_data 2 cycles after addr k; max_zbt_addr=8, capturing=0.
- Preload ZBT model addr 5=36'hABCDE; rd_addr=5 → rd_data=36'hABCDE after the phase-2 edge, unchanged through the next phase 1.
- DEPTH=4, 10 continuous writes → 4 accepted, state FULL, max_zbt_addr=4, overflow=1; a subsequent start clears overflow.
- Start mid-capture after 3 writes → wp restarts at 0; max_zbt_addr keeps its previous value until the next stop.
- start and stop in the same cycle, with a write accepted in that cycle → remains CAPTURE, wp=0 next cycle, max unchanged.
- reset_n pulsed low during an in-flight write → zbt_we=0 immediately, max_zbt_addr=0, no later zbt_write_data for the aborted write.
